stopwatch_ctrl: RTL and testbench

Sequencing controller for the stopwatch counter (`watch`). It converts single-cycle user button pulses (start/stop, lap, clear) into the watch's `enable`/`capture`/`read` control sequence. Each captured duration is stored in a small lap buffer. The buffer is drained by a downstream consumer (display/UART) over a valid/ready handshake.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/lap_fifo.sv | 74 +++++++
 rtl/stopwatch_ctrl.sv | 132 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and default widths for the stopwatch sequencing controller.
// The lap entry struct uses the default widths.
package stopwatch_pkg;

    localparam int DURATION_W_DEF = 8;
    localparam int ID_W_DEF       = 4;
    localparam int LAP_DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_CAP,
        S_RD,
        S_WAIT,
        S_STORE
    } state_t;

    typedef struct packed {
        logic [ID_W_DEF-1:0]       id;
        logic [DURATION_W_DEF-1:0] duration;
    } lap_entry_t;

    function automatic logic is_busy(state_t s);
        return (s inside {S_CAP, S_RD, S_WAIT, S_STORE});
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous FIFO with count, full flag and a registered head (first-word fall-through).
// The head register holds its last value when the FIFO drains or is flushed.
module lap_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] count_n;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && valid;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + 1'b1;

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_nxt;
            count <= count_n;
            valid <= (count_n != '0);
            if (do_pop) begin
                if (count > CW'(1))
                    head <= mem[rd_nxt];
                else if (do_push)
                    head <= din;
            end else if (do_push && count == '0) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Turns start/stop, lap and clear pulses into the watch enable/capture/read
// sequence and buffers each captured duration, tagged with a lap ID.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DURATION_W = DURATION_W_DEF,
    parameter int LAP_DEPTH  = LAP_DEPTH_DEF,
    parameter int ID_W       = ID_W_DEF,
    parameter int READ_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_start_stop,
    input  logic                         btn_lap,
    input  logic                         btn_clear,
    output logic                         watch_enable,
    output logic                         watch_capture,
    output logic                         watch_read,
    input  logic [DURATION_W-1:0]        watch_duration,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [DURATION_W-1:0]        lap_data,
    output logic [ID_W-1:0]              lap_id,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         overflow,
    output logic                         running,
    output logic                         busy
);
    localparam int WCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t          state, nstate, ret_st, nret;
    logic            ss_q, lap_q, clr_q;
    logic [WCW-1:0]  wcnt;
    logic [ID_W-1:0] id_cnt;
    logic            push, fifo_full;

    // Buttons are registered first, so a pulse sampled at edge k acts at edge k+1.
    always_comb begin
        nstate = state;
        nret   = ret_st;
        push   = 1'b0;
        if (clr_q) begin
            nstate = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ss_q) nstate = S_RUN;
                S_RUN: begin
                    if (ss_q) begin
                        nstate = S_CAP;
                        nret   = S_PAUSE;
                    end else if (lap_q) begin
                        nstate = S_CAP;
                        nret   = S_RUN;
                    end
                end
                S_PAUSE: if (ss_q) nstate = S_RUN;
                S_CAP:   nstate = S_RD;
                S_RD:    nstate = S_WAIT;
                S_WAIT: begin
                    if (wcnt == '0) begin
                        nstate = S_STORE;
                        push   = 1'b1;
                    end
                end
                S_STORE: nstate = ret_st;
                default: nstate = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_q          <= 1'b0;
            lap_q         <= 1'b0;
            clr_q         <= 1'b0;
            state         <= S_IDLE;
            ret_st        <= S_PAUSE;
            wcnt          <= '0;
            id_cnt        <= '0;
            overflow      <= 1'b0;
            watch_enable  <= 1'b0;
            watch_capture <= 1'b0;
            watch_read    <= 1'b0;
            running       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            ss_q   <= btn_start_stop;
            lap_q  <= btn_lap;
            clr_q  <= btn_clear;
            state  <= nstate;
            ret_st <= nret;

            if (state == S_RD)
                wcnt <= WCW'(READ_LAT - 1);
            else if (wcnt != '0)
                wcnt <= wcnt - 1'b1;

            // IDs advance on every push attempt so dropped laps leave a visible gap.
            if (clr_q) begin
                id_cnt   <= '0;
                overflow <= 1'b0;
            end else if (push) begin
                id_cnt <= id_cnt + 1'b1;
                if (fifo_full && !(lap_valid && lap_ready))
                    overflow <= 1'b1;
            end

            watch_enable  <= (nstate == S_RUN) || (is_busy(nstate) && watch_enable);
            watch_capture <= (nstate == S_CAP);
            watch_read    <= (nstate == S_RD);
            running       <= (nstate == S_RUN) || (is_busy(nstate) && nret == S_RUN);
            busy          <= is_busy(nstate);
        end
    end

    lap_fifo #(
        .W     (ID_W + DURATION_W),
        .DEPTH (LAP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clr_q),
        .push  (push),
        .pop   (lap_ready),
        .din   ({id_cnt, watch_duration}),
        .head  ({lap_id, lap_data}),
        .valid (lap_valid),
        .full  (fifo_full),
        .count (lap_count)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a queue of expected lap entries is filled
// as laps are requested and emptied as the consumer pops the buffer.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic       lap_ready = 1'b0;
    logic [7:0] watch_duration = 8'h00;
    logic       watch_enable, watch_capture, watch_read, lap_valid;
    logic       overflow, running, busy;
    logic [7:0] lap_data;
    logic [3:0] lap_id;
    logic [2:0] lap_count;

    int         n_cmp = 0, n_bad = 0;
    lap_entry_t exp_q[$];
    logic [3:0] next_id = 4'd0;
    bit         ovf_m = 1'b0;

    stopwatch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .watch_enable   (watch_enable),
        .watch_capture  (watch_capture),
        .watch_read     (watch_read),
        .watch_duration (watch_duration),
        .lap_valid      (lap_valid),
        .lap_ready      (lap_ready),
        .lap_data       (lap_data),
        .lap_id         (lap_id),
        .lap_count      (lap_count),
        .overflow       (overflow),
        .running        (running),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        btn_start_stop = 1'b1;
        step();
        btn_start_stop = 1'b0;
        step();
    endtask

    task automatic model_clear();
        exp_q.delete();
        next_id = 4'd0;
        ovf_m   = 1'b0;
    endtask

    task automatic pulse_clr();
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        step();
        model_clear();
    endtask

    // One capture sequence launched from RUN, by lap or by start_stop.
    task automatic do_cap(input bit via_ss, input logic [7:0] dur, input bit pop_on_push);
        lap_entry_t e;
        bit run_exp;
        run_exp    = !via_ss;
        e.id       = next_id;
        e.duration = dur;
        watch_duration = dur;
        if (exp_q.size() < LAP_DEPTH_DEF || pop_on_push) exp_q.push_back(e);
        else ovf_m = 1'b1;
        next_id++;
        if (via_ss) btn_start_stop = 1'b1; else btn_lap = 1'b1;
        step();                                   // edge k
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        chk("cap_early", 32'(watch_capture), 0);
        step();                                   // k+1
        chk("cap_k1", 32'(watch_capture), 1);
        chk("rd_k1", 32'(watch_read), 0);
        chk("busy_k1", 32'(busy), 1);
        chk("en_k1", 32'(watch_enable), 1);
        chk("run_k1", 32'(running), 32'(run_exp));
        step();                                   // k+2
        chk("cap_k2", 32'(watch_capture), 0);
        chk("rd_k2", 32'(watch_read), 1);
        step();                                   // k+3
        chk("rd_k3", 32'(watch_read), 0);
        chk("en_k3", 32'(watch_enable), 1);
        if (pop_on_push) begin
            chk("pop_head", 32'({lap_id, lap_data}), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            lap_ready = 1'b1;
        end
        step();                                   // k+4, push edge
        lap_ready = 1'b0;
        chk("cnt_k4", 32'(lap_count), exp_q.size());
        chk("vld_k4", 32'(lap_valid), 32'(exp_q.size() != 0));
        chk("busy_k4", 32'(busy), 1);
        step();                                   // k+5
        chk("busy_k5", 32'(busy), 0);
        chk("en_k5", 32'(watch_enable), 32'(run_exp));
        chk("run_k5", 32'(running), 32'(run_exp));
    endtask

    task automatic drain();
        lap_ready = 1'b1;
        for (int g = 0; g < 16 && exp_q.size() > 0; g++) begin
            chk("drain_vld", 32'(lap_valid), 1);
            chk("drain_entry", 32'({lap_id, lap_data}), 32'(exp_q.pop_front()));
            step();
        end
        lap_ready = 1'b0;
        chk("drain_cnt", 32'(lap_count), 0);
        chk("drain_vld_end", 32'(lap_valid), 0);
    endtask

    initial begin
        // Reset state, and lap ignored in IDLE
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_en", 32'(watch_enable), 0);
        chk("rst_cap", 32'(watch_capture), 0);
        chk("rst_rd", 32'(watch_read), 0);
        chk("rst_vld", 32'(lap_valid), 0);
        chk("rst_data", 32'(lap_data), 0);
        chk("rst_id", 32'(lap_id), 0);
        chk("rst_cnt", 32'(lap_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_run", 32'(running), 0);
        chk("rst_busy", 32'(busy), 0);
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_lap_cap", 32'(watch_capture), 0);
        end

        // First lap timing with duration 0x2A
        pulse_ss();
        chk("start_en", 32'(watch_enable), 1);
        chk("start_run", 32'(running), 1);
        do_cap(1'b0, 8'h2A, 1'b0);
        drain();

        // Overflow: five laps into a four-entry buffer
        pulse_clr();
        pulse_ss();
        for (int i = 1; i <= 5; i++) do_cap(1'b0, 8'(i * 10), 1'b0);
        chk("ovf_cnt", 32'(lap_count), exp_q.size());
        chk("ovf_flag", 32'(overflow), 32'(ovf_m));
        drain();
        do_cap(1'b0, 8'd60, 1'b0);
        drain();

        // Push and pop on the same edge with a full buffer
        pulse_clr();
        chk("clr_ovf", 32'(overflow), 0);
        pulse_ss();
        for (int i = 0; i < 4; i++) do_cap(1'b0, 8'(8'h80 + i), 1'b0);
        do_cap(1'b0, 8'h99, 1'b1);
        chk("pp_cnt", 32'(lap_count), 4);
        chk("pp_ovf", 32'(overflow), 32'(ovf_m));
        chk("pp_head", 32'({lap_id, lap_data}), 32'(exp_q[0]));
        drain();

        // Stop capture, lap ignored in PAUSE, resume
        do_cap(1'b1, 8'h33, 1'b0);
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pause_lap_cap", 32'(watch_capture), 0);
        end
        chk("pause_cnt", 32'(lap_count), exp_q.size());
        pulse_ss();
        chk("resume_en", 32'(watch_enable), 1);
        chk("resume_run", 32'(running), 1);

        // Clear while RD is active
        watch_duration = 8'h77;
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        step();
        step();
        chk("clr_rd_active", 32'(watch_read), 1);
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        step();
        model_clear();
        chk("clr_rd_en", 32'(watch_enable), 0);
        chk("clr_rd_busy", 32'(busy), 0);
        chk("clr_rd_vld", 32'(lap_valid), 0);
        chk("clr_rd_ovf", 32'(overflow), 0);
        step();
        step();
        chk("clr_rd_cnt", 32'(lap_count), exp_q.size());
        pulse_ss();
        do_cap(1'b0, 8'h44, 1'b0);
        drain();

        // Clear together with start_stop in PAUSE
        do_cap(1'b1, 8'h66, 1'b0);
        btn_clear      = 1'b1;
        btn_start_stop = 1'b1;
        step();
        btn_clear      = 1'b0;
        btn_start_stop = 1'b0;
        step();
        model_clear();
        chk("cs_en", 32'(watch_enable), 0);
        chk("cs_run", 32'(running), 0);
        chk("cs_vld", 32'(lap_valid), 0);
        chk("cs_cnt", 32'(lap_count), exp_q.size());
        chk("cs_ovf", 32'(overflow), 0);
        step();
        step();
        chk("cs_idle_en", 32'(watch_enable), 0);
        pulse_ss();
        do_cap(1'b0, 8'h55, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
